prco_led_port: RTL and testbench

PRCO_LED_PORT -- requirements
Module: prco_led_port

---
 rtl/prco_led_pkg.sv | 24 ++
 rtl/prco_led_blink.sv | 33 +++
 rtl/prco_led_port.sv | 118 +++++++++++
 tb/tb_prco_led_port.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prco_led_pkg.sv
// Shared register map, CTRL bit indices, reset values and FSM state type for the LED port.
package prco_led_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned LED_W  = 8;
    localparam int unsigned ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_CTRL     = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_PRESCALE = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_TOGGLE   = 2'd3;

    localparam int unsigned CTRL_BLINK_EN = 0;
    localparam int unsigned CTRL_INVERT   = 1;

    localparam logic [DATA_W-1:0] PRESCALE_RST = 16'hFFFF;
    localparam logic [LED_W-1:0]  BRIGHT_RST   = 8'hFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

endpackage

// File: rtl/prco_led_blink.sv
// Blink prescaler: counts 0..prescale while enabled and toggles phase on each wrap.
module prco_led_blink
    import prco_led_pkg::*;
(
    input  logic              clk50,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [DATA_W-1:0] prescale,
    output logic              phase
);

    logic [DATA_W-1:0] cnt;

    // load restarts the blink pattern from a known point; en=0 freezes both
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (load) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (en) begin
            if (cnt == prescale) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + DATA_W'(1);
            end
        end
    end

endmodule

// File: rtl/prco_led_port.sv
// Bus-mapped LED port with blink and invert; optional PWM brightness under PRCO_LED_PWM_EN.
module prco_led_port
    import prco_led_pkg::*;
(
    input  logic              clk50,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic [LED_W-1:0]  LEDS
);

    state_e            state;
    logic [LED_W-1:0]  data;
    logic [1:0]        ctrl;
    logic [DATA_W-1:0] prescale;
    logic              phase;
    logic              acc_c;
    logic              wr_c;
    logic              load_c;
    logic [DATA_W-1:0] rd_mux_c;
    logic [LED_W-1:0]  led_next_c;

    assign acc_c  = (state == ST_IDLE) && req;
    assign wr_c   = acc_c && we;
    assign load_c = wr_c && (addr == ADDR_PRESCALE);

`ifdef PRCO_LED_PWM_EN
    logic [LED_W-1:0] bright;
    logic [LED_W-1:0] pwmcnt;

    // free-running PWM ramp and brightness register in the upper byte of TOGGLE
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            bright <= BRIGHT_RST;
            pwmcnt <= '0;
        end else begin
            pwmcnt <= pwmcnt + LED_W'(1);
            if (wr_c && (addr == ADDR_TOGGLE))
                bright <= wdata[15:8];
        end
    end
`endif

    always_comb begin
        rd_mux_c = '0;
        case (addr)
            ADDR_DATA:     rd_mux_c = DATA_W'(data);
            ADDR_CTRL:     rd_mux_c = DATA_W'(ctrl);
            ADDR_PRESCALE: rd_mux_c = prescale;
`ifdef PRCO_LED_PWM_EN
            ADDR_TOGGLE:   rd_mux_c = {bright, 8'h00};
`else
            ADDR_TOGGLE:   rd_mux_c = '0;
`endif
            default:       rd_mux_c = '0;
        endcase
    end

    always_comb begin
        led_next_c = (data & {LED_W{phase | ~ctrl[CTRL_BLINK_EN]}}) ^ {LED_W{ctrl[CTRL_INVERT]}};
`ifdef PRCO_LED_PWM_EN
        if (pwmcnt >= bright)
            led_next_c = '0;
`endif
    end

    prco_led_blink u_blink (
        .clk50    (clk50),
        .rst      (rst),
        .en       (ctrl[CTRL_BLINK_EN]),
        .load     (load_c),
        .prescale (prescale),
        .phase    (phase)
    );

    // handshake FSM and register file; req is ignored in ACK to force an idle gap
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ack      <= 1'b0;
            rdata    <= '0;
            data     <= '0;
            ctrl     <= '0;
            prescale <= PRESCALE_RST;
            LEDS     <= '0;
        end else begin
            LEDS  <= led_next_c;
            ack   <= 1'b0;
            rdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state <= ST_ACK;
                        ack   <= 1'b1;
                        if (we) begin
                            case (addr)
                                ADDR_DATA:     data     <= wdata[7:0];
                                ADDR_CTRL:     ctrl     <= wdata[1:0];
                                ADDR_PRESCALE: prescale <= wdata;
                                ADDR_TOGGLE:   data     <= data ^ wdata[7:0];
                                default:       data     <= data;
                            endcase
                        end else begin
                            rdata <= rd_mux_c;
                        end
                    end
                end
                ST_ACK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prco_led_port.sv
// Randomized self-checking bench for prco_led_port against a cycle-count reference model.
module tb_prco_led_port;

    logic        clk50 = 1'b0;
    logic        rst   = 1'b1;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [1:0]  addr  = 2'd0;
    logic [15:0] wdata = 16'd0;
    logic        ack;
    logic [15:0] rdata;
    logic [7:0]  LEDS;

    int n_check = 0;
    int n_pass  = 0;

    // reference model: register contents plus "enabled cycles since last PRESCALE write"
    logic [7:0]  m_data;
    logic [1:0]  m_ctrl;
    logic [15:0] m_ps;
    logic [7:0]  m_bright;
    int          m_en_cyc;
    int          m_cyc;
    logic        m_ack;
    logic [15:0] exp_rdata;
    logic [7:0]  exp_leds;

    prco_led_port dut (
        .clk50 (clk50),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .ack   (ack),
        .rdata (rdata),
        .LEDS  (LEDS)
    );

    always #10 clk50 = ~clk50;

    function automatic logic [7:0] model_leds();
        int   per;
        logic ph;
        logic [7:0] v;
        per = int'(m_ps) + 1;
        ph  = ((m_en_cyc / per) % 2) == 1;
        v   = (ph || !m_ctrl[0]) ? m_data : 8'h00;
        if (m_ctrl[1]) v = ~v;
`ifdef PRCO_LED_PWM_EN
        if ((m_cyc % 256) >= int'(m_bright)) v = 8'h00;
`endif
        return v;
    endfunction

    function automatic logic [15:0] model_read(input logic [1:0] a);
        case (a)
            2'd0: return {8'h00, m_data};
            2'd1: return {14'd0, m_ctrl};
            2'd2: return m_ps;
`ifdef PRCO_LED_PWM_EN
            default: return {m_bright, 8'h00};
`else
            default: return 16'h0000;
`endif
        endcase
    endfunction

    task automatic model_reset();
        m_data = 8'h00; m_ctrl = 2'b00; m_ps = 16'hFFFF; m_bright = 8'hFF;
        m_en_cyc = 0; m_cyc = 0; m_ack = 1'b0; exp_rdata = 16'h0000; exp_leds = 8'h00;
    endtask

    // advance one clock, applying the bus rules to the model with pre-edge values
    task automatic tick();
        logic [7:0] nl;
        logic       acc;
        @(posedge clk50);
        nl  = model_leds();
        acc = req && !m_ack;
        if (acc && we && addr == 2'd2) m_en_cyc = 0;
        else if (m_ctrl[0])            m_en_cyc++;
        exp_rdata = 16'h0000;
        if (acc) begin
            if (we) begin
                case (addr)
                    2'd0: m_data = wdata[7:0];
                    2'd1: m_ctrl = wdata[1:0];
                    2'd2: m_ps   = wdata;
                    default: begin
                        m_data = m_data ^ wdata[7:0];
`ifdef PRCO_LED_PWM_EN
                        m_bright = wdata[15:8];
`endif
                    end
                endcase
            end else begin
                exp_rdata = model_read(addr);
            end
        end
        m_ack = acc;
        m_cyc++;
        exp_leds = nl;
        #1;
    endtask

    task automatic bus(input logic w, input logic [1:0] a, input logic [15:0] d);
        req = 1'b1; we = w; addr = a; wdata = d;
        tick();
        req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0;
        repeat (2) @(posedge clk50);
        #1;
        n_check++; if (ack !== 1'b0) $display("FAIL reset_ack got %0b want 0", ack); else n_pass++;
        n_check++; if (rdata !== 16'h0000) $display("FAIL reset_rdata got %h want 0000", rdata); else n_pass++;
        n_check++; if (LEDS !== 8'h00) $display("FAIL reset_leds got %h want 00", LEDS); else n_pass++;
        rst = 1'b0;
        model_reset();
        for (int a = 0; a < 4; a++) begin
            req = 1'b1; we = 1'b0; addr = 2'(a);
            tick();
            req = 1'b0;
            n_check++; if (ack !== 1'b1) $display("FAIL reset_read_ack a=%0d got %0b want 1", a, ack); else n_pass++;
            n_check++; if (rdata !== exp_rdata) $display("FAIL reset_read a=%0d got %h want %h", a, rdata, exp_rdata); else n_pass++;
            tick();
        end
    endtask

    task automatic test_data_write();
        req = 1'b1; we = 1'b1; addr = 2'd0; wdata = 16'h00A5;
        tick();
        req = 1'b0;
        n_check++; if (ack !== 1'b1) $display("FAIL wr_ack got %0b want 1", ack); else n_pass++;
        n_check++; if (LEDS !== exp_leds) $display("FAIL wr_leds_early got %h want %h", LEDS, exp_leds); else n_pass++;
        tick();
        n_check++; if (ack !== 1'b0) $display("FAIL wr_ack_pulse got %0b want 0", ack); else n_pass++;
        n_check++; if (LEDS !== exp_leds) $display("FAIL wr_leds got %h want %h", LEDS, exp_leds); else n_pass++;
    endtask

    task automatic test_blink();
        logic [7:0] prev;
        int changes;
        bus(1'b1, 2'd0, 16'h00FF);
        bus(1'b1, 2'd2, 16'h0003);
        bus(1'b1, 2'd1, 16'h0001);
        prev = LEDS;
        changes = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            n_check++; if (LEDS !== exp_leds) $display("FAIL blink_leds cyc=%0d got %h want %h", i, LEDS, exp_leds); else n_pass++;
            if (LEDS !== prev) changes++;
            prev = LEDS;
        end
`ifndef PRCO_LED_PWM_EN
        n_check++; if (changes != 8) $display("FAIL blink_period got %0d changes want 8", changes); else n_pass++;
`endif
        bus(1'b1, 2'd1, 16'h0002);
        repeat (3) begin
            tick();
            n_check++; if (LEDS !== exp_leds) $display("FAIL invert_leds got %h want %h", LEDS, exp_leds); else n_pass++;
        end
        bus(1'b1, 2'd1, 16'h0000);
    endtask

    task automatic test_toggle();
        bus(1'b1, 2'd0, 16'h00A5);
        bus(1'b1, 2'd3, 16'hFF0F);
        req = 1'b1; we = 1'b0; addr = 2'd0;
        tick();
        req = 1'b0;
        n_check++; if (rdata !== exp_rdata) $display("FAIL toggle_data got %h want %h", rdata, exp_rdata); else n_pass++;
        n_check++; if (rdata !== 16'h00AA) $display("FAIL toggle_data_abs got %h want 00aa", rdata); else n_pass++;
        tick();
        req = 1'b1; we = 1'b0; addr = 2'd3;
        tick();
        req = 1'b0;
        n_check++; if (rdata !== exp_rdata) $display("FAIL toggle_read3 got %h want %h", rdata, exp_rdata); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int acks;
        acks = 0;
        req = 1'b1; we = 1'b1; addr = 2'd3; wdata = 16'hFF01;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_check++; if (ack !== m_ack) $display("FAIL b2b_ack cyc=%0d got %0b want %0b", i, ack, m_ack); else n_pass++;
            if (ack === 1'b1) acks++;
        end
        req = 1'b0;
        tick();
        n_check++; if (acks != 4) $display("FAIL b2b_count got %0d want 4", acks); else n_pass++;
        req = 1'b1; we = 1'b0; addr = 2'd0;
        tick();
        req = 1'b0;
        n_check++; if (rdata !== exp_rdata) $display("FAIL b2b_data got %h want %h", rdata, exp_rdata); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        req = 1'b1; we = 1'b1; addr = 2'd0; wdata = 16'h003C;
        tick();
        req = 1'b0;
        n_check++; if (ack !== 1'b1) $display("FAIL mid_ack_pre got %0b want 1", ack); else n_pass++;
        rst = 1'b1;
        #1;
        n_check++; if (ack !== 1'b0) $display("FAIL mid_ack got %0b want 0", ack); else n_pass++;
        n_check++; if (LEDS !== 8'h00) $display("FAIL mid_leds got %h want 00", LEDS); else n_pass++;
        @(posedge clk50);
        #1;
        rst = 1'b0;
        model_reset();
        req = 1'b1; we = 1'b0; addr = 2'd0;
        tick();
        req = 1'b0;
        n_check++; if (ack !== 1'b1) $display("FAIL mid_reread_ack got %0b want 1", ack); else n_pass++;
        n_check++; if (rdata !== 16'h0000) $display("FAIL mid_data got %h want 0000", rdata); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [1:0] a;
        for (int n = 0; n < 150; n++) begin
            a = 2'($urandom_range(0, 3));
            req = 1'b1; we = 1'($urandom); addr = a;
            wdata = (a == 2'd2) ? 16'($urandom_range(0, 7)) : 16'($urandom);
            tick();
            req = 1'b0;
            for (int g = 0; g < 1 + int'($urandom_range(0, 3)); g++) begin
                n_check++; if (ack !== m_ack) $display("FAIL rnd_ack n=%0d got %0b want %0b", n, ack, m_ack); else n_pass++;
                n_check++; if (rdata !== exp_rdata) $display("FAIL rnd_rdata n=%0d got %h want %h", n, rdata, exp_rdata); else n_pass++;
                n_check++; if (LEDS !== exp_leds) $display("FAIL rnd_leds n=%0d got %h want %h", n, LEDS, exp_leds); else n_pass++;
                tick();
            end
        end
    endtask

`ifdef PRCO_LED_PWM_EN
    task automatic test_pwm();
        int on_cnt;
        bus(1'b1, 2'd1, 16'h0000);
        bus(1'b1, 2'd3, 16'h4000);
        bus(1'b1, 2'd0, 16'h00FF);
        tick();
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            n_check++; if (LEDS !== exp_leds) $display("FAIL pwm_leds cyc=%0d got %h want %h", i, LEDS, exp_leds); else n_pass++;
            if (LEDS === 8'hFF) on_cnt++;
        end
        n_check++; if (on_cnt != 64) $display("FAIL pwm_duty got %0d want 64", on_cnt); else n_pass++;
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_data_write();
        test_blink();
        test_toggle();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef PRCO_LED_PWM_EN
        test_pwm();
`endif
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
